// File: rtl/ras_ctrl.sv
// Return-address-stack controller with speculative checkpoint levels.
// Accepts decoded call/return/branch ops and issues stack push/pop commands.
// It also tracks outstanding branches per checkpoint level, and turns
// in-order branch resolutions into per-level commit/flush pulses.

// Per-level outstanding-branch counter. It clears on flush and saturates
// instead of wrapping.
module ras_lvl_cnt #(
    parameter int CW = 5
) (
    input  logic          clk,
    input  logic          rst_ni,
    input  logic          clr,
    input  logic          inc,
    input  logic          dec,
    output logic [CW-1:0] cnt
);

    // An increment and a decrement in the same cycle cancel out.
    always_ff @(posedge clk) begin
        if (!rst_ni)                         cnt <= '0;
        else if (clr)                        cnt <= '0;
        else if (inc && !dec && cnt != '1)   cnt <= cnt + CW'(1);
        else if (dec && !inc && cnt != '0)   cnt <= cnt - CW'(1);
    end

endmodule

module ras_ctrl #(
    parameter int STAGES       = 2,
    parameter int WIDTH        = 32,
    parameter int MAX_BRANCHES = 16
) (
    input  logic              clk,
    input  logic              rst_ni,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_call,
    input  logic              in_ret,
    input  logic              in_branch,
    input  logic [WIDTH-1:0]  in_ret_addr,
    input  logic [STAGES-1:0] res_valid,
    input  logic [STAGES-1:0] res_ok,
    output logic              ras_push,
    output logic              ras_pop,
    output logic [WIDTH-1:0]  ras_din,
    output logic [STAGES-1:0] ras_commit,
    output logic [STAGES-1:0] ras_flush,
    input  logic [WIDTH-1:0]  ras_dout,
    input  logic              ras_empty,
    output logic              pred_valid,
    output logic [WIDTH-1:0]  pred_target,
    output logic              err
);

    localparam int CW = $clog2(MAX_BRANCHES + 1);

    localparam logic [1:0] S_INIT    = 2'd0;
    localparam logic [1:0] S_RUN     = 2'd1;
    localparam logic [1:0] S_RECOVER = 2'd2;

    logic [1:0]                 state;
    logic [STAGES-1:0][CW-1:0]  count;
    logic [STAGES-1:0]          has;
    logic [STAGES-1:0]          flush_v;
    logic [STAGES-1:0]          clr;
    logic [STAGES-1:0]          cm;
    logic [STAGES-1:0]          inc;
    logic                       active;
    logic                       full;
    logic                       acc;

    // Resolutions are only honoured once out of reset and past INIT.
    assign active = rst_ni && (state == S_RUN || state == S_RECOVER);
    assign full   = (count[0] == CW'(MAX_BRANCHES));

    // Per-level resolution decode. A flush at level k clears every level
    // at or below k, so clr[j] is an OR of the flushes at levels >= j.
    // Commits on cleared levels are suppressed.
    always_comb begin
        logic run_or;
        run_or = 1'b0;
        has    = '0;
        flush_v = '0;
        clr    = '0;
        cm     = '0;
        for (int j = STAGES - 1; j >= 0; j--) begin
            has[j]     = (count[j] != '0);
            flush_v[j] = active && res_valid[j] && !res_ok[j] && has[j];
            run_or     = run_or | flush_v[j];
            clr[j]     = run_or;
            cm[j]      = active && res_valid[j] && res_ok[j] && has[j] && !run_or;
        end
    end

    // A branch is held off only while level 0 is full; other ops still pass.
    // Any flush stalls acceptance for this cycle.
    assign in_ready = rst_ni && (state == S_RUN) && !clr[0] && !(full && in_branch);
    assign acc      = in_valid && in_ready;

    // Stack commands and prediction are combinational off the accepted op.
    always_comb begin
        ras_push    = acc && in_call;
        ras_pop     = acc && in_ret;
        ras_din     = (acc && in_call) ? in_ret_addr : '0;
        pred_valid  = acc && in_ret && !ras_empty;
        pred_target = (acc && in_ret) ? ras_dout : '0;
    end

    assign ras_commit = cm;
    assign ras_flush  = flush_v;

    // Level 0 is fed by accepted branches. Each higher level is fed by
    // commits from the level below it. A commit at the top level retires.
    for (genvar g = 0; g < STAGES; g++) begin : g_lvl
        if (g == 0) begin : g_src0
            assign inc[g] = acc && in_branch;
        end else begin : g_srcn
            assign inc[g] = cm[g-1];
        end
        ras_lvl_cnt #(.CW(CW)) u_cnt (
            .clk    (clk),
            .rst_ni (rst_ni),
            .clr    (clr[g]),
            .inc    (inc[g]),
            .dec    (cm[g]),
            .cnt    (count[g])
        );
    end

    // INIT lasts one cycle. A flush sends the FSM to RECOVER for one cycle
    // so the stack top can be re-read.
    always_ff @(posedge clk) begin
        if (!rst_ni)              state <= S_INIT;
        else if (state == S_INIT) state <= S_RUN;
        else if (clr[0])          state <= S_RECOVER;
        else                      state <= S_RUN;
    end

    // Sticky error: a resolution arrived for a level with nothing outstanding.
    always_ff @(posedge clk) begin
        if (!rst_ni)                           err <= 1'b0;
        else if (active && |(res_valid & ~has)) err <= 1'b1;
    end

endmodule
